// File: rtl/common_pseudo_lru_setpick_if.sv
// common_pseudo_lru_setpick_if: touch/pick request bus and registered pick result for the set-associative pseudo-LRU picker
interface common_pseudo_lru_setpick_if #(
  parameter int WAY_COUNT_LOG2 = 2,
  parameter int SET_COUNT_LOG2 = 4
);
  localparam int WAYS = 1 << WAY_COUNT_LOG2;
  localparam int SW = SET_COUNT_LOG2 > 0 ? SET_COUNT_LOG2 : 1;
  logic [SW-1:0] tset;
  logic [WAY_COUNT_LOG2-1:0] tway;
  logic ten;
  logic [SW-1:0] pset;
  logic pen;
  logic palloc;
  logic [WAYS-1:0] dvalid;
  logic [WAYS-1:0] dlock;
  logic [WAY_COUNT_LOG2-1:0] qway;
  logic qvalid;
  modport master (
    output tset, tway, ten, pset, pen, palloc, dvalid, dlock,
    input qway, qvalid
  );
  modport slave (
    input tset, tway, ten, pset, pen, palloc, dvalid, dlock,
    output qway, qvalid
  );
endinterface

// File: rtl/common_pseudo_lru_setpick.sv
// common_pseudo_lru_setpick: per-set tree pseudo-LRU victim picker with valid/lock awareness and touch/allocate updates
module common_pseudo_lru_setpick #(
  parameter int WAY_COUNT_LOG2 = 2,
  parameter int SET_COUNT_LOG2 = 4
) (
  input logic clk,
  input logic resetn,
  common_pseudo_lru_setpick_if.slave lru
);
  localparam int WL = WAY_COUNT_LOG2;
  localparam int WAYS = 1 << WL;
  localparam int SETS = 1 << SET_COUNT_LOG2;
  localparam int SW = SET_COUNT_LOG2 > 0 ? SET_COUNT_LOG2 : 1;
  logic [WAYS-1:1] tree [SETS];
  logic [WAYS-1:1] nxt [SETS];
  logic [WAYS-1:1] cur;
  logic [2*WAYS-1:1] lk;
  logic [SW-1:0] ts, ps;
  logic [WL-1:0] pk, fw;
  logic hit, ok, alloc;
  int n;
  logic b;
  // Each node on the path to w is pointed at the sibling of w's subtree.
  function automatic logic [WAYS-1:1] touch(input logic [WAYS-1:1] t, input logic [WL-1:0] w);
    for (int d = 0; d < WL; d++) t[(1 << d) | (int'(w) >> (WL - d))] = ~w[WL-1-d];
    return t;
  endfunction
  assign ts = SET_COUNT_LOG2 == 0 ? '0 : lru.tset;
  assign ps = SET_COUNT_LOG2 == 0 ? '0 : lru.pset;
  assign cur = tree[ps];
  // lk is heap-indexed like the tree, with leaves at WAYS+way: a node is set when its whole subtree is locked.
  always_comb begin
    lk = '0;
    lk[2*WAYS-1:WAYS] = lru.dlock;
    for (int i = WAYS - 1; i >= 1; i--) lk[i] = lk[2*i] & lk[2*i+1];
  end
  always_comb begin
    hit = 1'b0;
    fw = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!lru.dvalid[w] && !lru.dlock[w]) begin
        hit = 1'b1;
        fw = WL'(w);
      end
  end
  always_comb begin
    n = 1;
    b = 1'b0;
    for (int d = 0; d < WL; d++) begin
      b = cur[n];
      b = lk[2*n+int'(b)] ? ~b : b;
      n = 2 * n + int'(b);
    end
  end
  assign ok = ~lk[1];
  assign pk = hit ? fw : WL'(n - WAYS);
  assign alloc = lru.pen & lru.palloc & ok;
  // Touch is applied before the allocate so the allocate wins on shared nodes.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      nxt[s] = tree[s];
      if (lru.ten && ts == SW'(s)) nxt[s] = touch(nxt[s], lru.tway);
      if (alloc && ps == SW'(s)) nxt[s] = touch(nxt[s], pk);
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
      lru.qway <= '0;
      lru.qvalid <= 1'b0;
    end else begin
      for (int s = 0; s < SETS; s++) tree[s] <= nxt[s];
      lru.qvalid <= lru.pen & ok;
      lru.qway <= (lru.pen && ok) ? pk : '0;
    end
endmodule

// File: doc/common_pseudo_lru_setpick.md
COMMON_PSEUDO_LRU_SETPICK -- requirements
Module: common_pseudo_lru_setpick

Interface
REQ-001 SHALL have parameter WAY_COUNT_LOG2, default 2, log2 of ways per set (legal range 1..5).
REQ-002 SHALL have parameter SET_COUNT_LOG2, default 4, log2 of independent sets (legal range 0..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port tset  input  max(SET_COUNT_LOG2,1)  touch set index (ignored when SET_COUNT_LOG2=0).
REQ-006 SHALL have port tway  input  WAY_COUNT_LOG2  touched way.
REQ-007 SHALL have port ten  input  1  touch enable; marks tway most-recently-used in tset.
REQ-008 SHALL have port pset  input  max(SET_COUNT_LOG2,1)  pick set index.
REQ-009 SHALL have port pen  input  1  pick request.
REQ-010 SHALL have port palloc  input  1  pick-and-allocate; the picked way also becomes MRU (qualified by pen).
REQ-011 SHALL have port dvalid  input  2^WAY_COUNT_LOG2  per-way valid bits of set pset.
REQ-012 SHALL have port dlock  input  2^WAY_COUNT_LOG2  per-way lock bits; locked ways are never picked.
REQ-013 SHALL have port qway  output  WAY_COUNT_LOG2  registered picked way.
REQ-014 SHALL have port qvalid  output  1  registered; qway is meaningful.

Function
REQ-015 SHALL hold, per set, a binary tree of 2^WAY_COUNT_LOG2-1 bits, heap-indexed: root node 1, children of node n are 2n (lower ways) and 2n+1 (upper ways).
REQ-016 SHALL interpret tree bit 0 as "victim in lower subtree" and 1 as "victim in upper subtree".
REQ-017 SHALL, on a touch of way w, set every node on the root-to-w path to point away from w; nodes off the path are unchanged.
REQ-018 SHALL compute the pick from the tree state, dvalid and dlock as sampled in the cycle of pen, using tree contents before that edge's updates (read-old).
REQ-019 SHALL pick, first, the lowest-index way with dvalid=0 and dlock=0, if any.
REQ-020 SHALL otherwise walk the tree from the root following node bits, except that when the indicated subtree is fully locked the walk takes the sibling subtree.
REQ-021 SHALL, when every way is locked, drive qvalid=0 and qway=0.
REQ-022 SHALL register qway/qvalid one cycle after pen (latency 1); a cycle with pen=0 yields qvalid=0 and qway=0 next cycle.
REQ-023 SHALL, when pen=1, palloc=1 and a way is picked, apply a touch of the picked way to pset at the same edge; no update when qvalid would be 0.
REQ-024 SHALL, when ten and an allocating pick target the same set in one cycle, apply the touch first and the allocate second (allocate wins on shared nodes).
REQ-025 SHALL, when they target different sets, apply both updates independently.
REQ-026 SHALL leave sets other than tset/pset unchanged.
REQ-027 SHALL accept back-to-back picks and touches every cycle with no stall or busy state.

Reset
REQ-028 SHALL, on resetn low, asynchronously clear all tree bits of all sets to 0, with qway=0 and qvalid=0.
REQ-029 SHALL ignore ten/pen while resetn is low; the first pick after release in any set with all ways valid and unlocked returns way 0.
REQ-030 SHALL discard an in-flight pick result if reset asserts between request and response.

Verification (WAY_COUNT_LOG2=2, SET_COUNT_LOG2=4)
REQ-031 Reset, pen=1 pset=0 dvalid=1111 dlock=0000 palloc=0 -> next cycle qvalid=1 qway=0; repeating gives qway=0 (no update).
REQ-032 Set 0: touch 0, pick -> qway=2; touch 2, pick -> qway=1; touch 1, pick -> qway=3; set 5 pick -> qway=0.
REQ-033 Four consecutive allocating picks on set 0 from reset (dvalid=1111) -> qway sequence 0,2,1,3, fifth pick -> 0.
REQ-034 dvalid=1011 with any tree state -> qway=2; dvalid=1011 dlock=0100 -> tree-walk result, never 2.
REQ-035 From reset, dlock=0011 dvalid=1111 -> qway=2; dlock=1111 -> qvalid=0 qway=0, no tree change.
REQ-036 Same cycle ten=1 tway=0 and allocating pick on set 0 picking way 3 -> root bit 0, following pick -> qway=1; reset pulse mid-sequence -> qvalid=0 next cycle, subsequent pick -> qway=0.
